spi_packet_master_rx: RTL

// - FPGA-side SPI Mode-0 master; reads one 16-byte sensor packet per request from a read-only SPI slave.
// - Drives cs_n/sck and ties MOSI low; samples MISO; validates header 0xAA; unpacks quat/gyro/flags.
// - Used on the bench/loopback board to read the sensor packet link end-to-end; packet layout matches the MCU-side decoder.

---
 rtl/spi_pkt_pkg.sv | 41 ++++
 rtl/spi_packet_master_rx_clkgen.sv | 39 +++
 rtl/spi_packet_master_rx.sv | 102 ++++++++++
 3 files changed

// File: rtl/spi_pkt_pkg.sv
// Shared definitions for the 16-byte sensor packet link: layout, header and FSM states.
package spi_pkt_pkg;
  localparam int         PACKET_SIZE = 16;
  localparam int         PACKET_BITS = PACKET_SIZE * 8;
  localparam logic [7:0] HEADER_BYTE = 8'hAA;

  localparam int OFF_QW = 1, OFF_QX = 3, OFF_QY = 5, OFF_QZ = 7;
  localparam int OFF_GX = 9, OFF_GY = 11, OFF_GZ = 13, OFF_FLAGS = 15;

  localparam int FLAG_QUAT_VALID = 0, FLAG_GYRO_VALID = 1, FLAG_INIT = 2, FLAG_ERROR = 3;

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_HOLD, ST_DONE} state_t;

  typedef struct packed {
    logic [15:0] qw, qx, qy, qz;
    logic [15:0] gx, gy, gz;
    logic [7:0]  flags;
  } spi_pkt_t;

  // Byte 0 is the first byte on the wire and therefore sits at the top of the shift register.
  function automatic logic [7:0] pkt_byte(input logic [PACKET_BITS-1:0] sr, input int idx);
    return sr[PACKET_BITS-1-8*idx -: 8];
  endfunction

  function automatic logic [15:0] pkt_word(input logic [PACKET_BITS-1:0] sr, input int idx);
    return {pkt_byte(sr, idx), pkt_byte(sr, idx + 1)};
  endfunction

  function automatic spi_pkt_t pkt_unpack(input logic [PACKET_BITS-1:0] sr);
    spi_pkt_t p;
    p.qw    = pkt_word(sr, OFF_QW);
    p.qx    = pkt_word(sr, OFF_QX);
    p.qy    = pkt_word(sr, OFF_QY);
    p.qz    = pkt_word(sr, OFF_QZ);
    p.gx    = pkt_word(sr, OFF_GX);
    p.gy    = pkt_word(sr, OFF_GY);
    p.gz    = pkt_word(sr, OFF_GZ);
    p.flags = pkt_byte(sr, OFF_FLAGS);
    return p;
  endfunction
endpackage

// File: rtl/spi_packet_master_rx_clkgen.sv
// SPI Mode-0 SCK generator: divider, sck, rise strobe and 128-bit end-of-transfer detect.
module spi_mode0_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic done_o
);
  logic [15:0] div_q;
  logic        sck_q;
  logic [6:0]  bit_cnt_q;
  logic        tick, fall;

  assign tick   = en_i && (div_q == 16'(CLK_DIV - 1));
  assign rise_o = tick && !sck_q;
  assign fall   = tick && sck_q;
  // The counter wraps to 0 on rise #128; the fall after it ends the transfer.
  assign done_o = fall && (bit_cnt_q == 7'd0);
  assign sck_o  = sck_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q     <= '0;
      sck_q     <= 1'b0;
      bit_cnt_q <= '0;
    end else if (!en_i) begin
      div_q     <= '0;
      sck_q     <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 16'd1;
      if (tick)   sck_q     <= !sck_q;
      if (rise_o) bit_cnt_q <= bit_cnt_q + 7'd1;
    end
  end
endmodule

// File: rtl/spi_packet_master_rx.sv
// SPI Mode-0 master reading one 16-byte sensor packet per start; checks header, unpacks fields.
module spi_packet_master_rx #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               cs_n_o,
  output logic               sck_o,
  output logic               mosi_o,
  input  logic               miso_i,
  output logic               pkt_valid_o,
  output logic               hdr_err_o,
  output logic signed [15:0] quat_w_o,
  output logic signed [15:0] quat_x_o,
  output logic signed [15:0] quat_y_o,
  output logic signed [15:0] quat_z_o,
  output logic signed [15:0] gyro_x_o,
  output logic signed [15:0] gyro_y_o,
  output logic signed [15:0] gyro_z_o,
  output logic [7:0]         flags_o
);
  import spi_pkt_pkg::*;

  state_t                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   cs_n_q, cs_n_d;
  logic [PACKET_BITS-1:0] sr_q;
  spi_pkt_t               pkt_q;
  logic                   pkt_valid_q, hdr_err_q;
  logic                   rise, xfer_done;

  spi_mode0_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state_q == ST_XFER),
    .sck_o  (sck_o),
    .rise_o (rise),
    .done_o (xfer_done)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) begin state_d = ST_SETUP; cnt_d = '0; end
      ST_SETUP: if (cnt_q == 16'(CS_SETUP - 1)) begin state_d = ST_XFER; cnt_d = '0; end
                else cnt_d = cnt_q + 16'd1;
      ST_XFER:  if (xfer_done) begin state_d = ST_HOLD; cnt_d = '0; end
      ST_HOLD:  if (cnt_q == 16'(CS_HOLD - 1)) state_d = ST_DONE;
                else cnt_d = cnt_q + 16'd1;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Registered off the next state so cs_n drops with SETUP entry and rises with DONE entry.
    cs_n_d = !(state_d inside {ST_SETUP, ST_XFER, ST_HOLD});
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cs_n_q      <= 1'b1;
      sr_q        <= '0;
      pkt_q       <= '0;
      pkt_valid_q <= 1'b0;
      hdr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_n_q      <= cs_n_d;
      pkt_valid_q <= 1'b0;
      hdr_err_q   <= 1'b0;
      if (rise) sr_q <= {sr_q[PACKET_BITS-2:0], miso_i};
      if (state_q == ST_DONE) begin
        if (pkt_byte(sr_q, 0) == HEADER_BYTE) begin
          pkt_q       <= pkt_unpack(sr_q);
          pkt_valid_q <= 1'b1;
        end else begin
          hdr_err_q   <= 1'b1;
        end
      end
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign cs_n_o      = cs_n_q;
  assign mosi_o      = 1'b0;
  assign pkt_valid_o = pkt_valid_q;
  assign hdr_err_o   = hdr_err_q;
  assign quat_w_o    = pkt_q.qw;
  assign quat_x_o    = pkt_q.qx;
  assign quat_y_o    = pkt_q.qy;
  assign quat_z_o    = pkt_q.qz;
  assign gyro_x_o    = pkt_q.gx;
  assign gyro_y_o    = pkt_q.gy;
  assign gyro_z_o    = pkt_q.gz;
  assign flags_o     = pkt_q.flags;
endmodule
